// File: rtl/fifo_bank4_pkg.sv
// Shared constants and types for the four-channel FIFO bank.
package fifo_bank4_pkg;

    localparam int unsigned BANK_DATA_W   = 12;
    localparam int unsigned BANK_NUM_CH   = 4;
    localparam int unsigned BANK_DEPTH    = 8;
    localparam int unsigned BANK_AF_TH    = 6;
    localparam int unsigned BANK_AE_TH    = 1;
    localparam int unsigned BANK_CH_ID_W  = 2;

    typedef logic [BANK_CH_ID_W-1:0] ch_id_t;

endpackage

// File: rtl/fifo_ch.sv
// One FIFO channel: circular buffer, occupancy counter, status decodes and
// a sticky overflow/underflow flag. Reads are registered (1-cycle latency).
module fifo_ch
    import fifo_bank4_pkg::*;
#(
    parameter int unsigned DATA_W = BANK_DATA_W,
    parameter int unsigned DEPTH  = BANK_DEPTH,
    parameter int unsigned AF_TH  = BANK_AF_TH,
    parameter int unsigned AE_TH  = BANK_AE_TH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              full,
    output logic              err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_err;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_fault;
    logic [CNT_W-1:0]  w_count_nxt;

    // A full channel still accepts a push when a pop frees the slot on the
    // same edge; an empty channel never accepts a pop (no write-through).
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;
    assign w_fault   = (push & full & ~pop) | (pop & empty);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_err   <= r_err | w_fault;
        end
    end

    assign data_out     = r_data_out;
    assign err          = r_err;
    assign empty        = (r_count == '0);
    assign full         = (r_count == CNT_W'(DEPTH));
    assign almost_full  = (r_count >= CNT_W'(AF_TH));
    assign almost_empty = (r_count <= CNT_W'(AE_TH));

endmodule

// File: rtl/fifo_bank4.sv
// Bank of four independent FIFO channels sharing one write word.
module fifo_bank4
    import fifo_bank4_pkg::*;
#(
    parameter int unsigned DATA_W = BANK_DATA_W,
    parameter int unsigned DEPTH  = BANK_DEPTH,
    parameter int unsigned AF_TH  = BANK_AF_TH,
    parameter int unsigned AE_TH  = BANK_AE_TH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BANK_NUM_CH-1:0]        push,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [BANK_NUM_CH-1:0]        pop,
    output logic [BANK_NUM_CH*DATA_W-1:0] data_out,
    output logic [BANK_NUM_CH-1:0]        empty,
    output logic [BANK_NUM_CH-1:0]        almost_empty,
    output logic [BANK_NUM_CH-1:0]        almost_full,
    output logic [BANK_NUM_CH-1:0]        full,
    output logic [BANK_NUM_CH-1:0]        err,
    output logic                          idle
);

    for (genvar g = 0; g < BANK_NUM_CH; g++) begin : g_ch
        fifo_ch #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AF_TH  (AF_TH),
            .AE_TH  (AE_TH)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .push         (push[g]),
            .pop          (pop[g]),
            .data_in      (data_in),
            .data_out     (data_out[g*DATA_W +: DATA_W]),
            .empty        (empty[g]),
            .almost_empty (almost_empty[g]),
            .almost_full  (almost_full[g]),
            .full         (full[g]),
            .err          (err[g])
        );
    end

    assign idle = &empty;

endmodule

// File: tb/tb_fifo_bank4.sv
// Directed bench for fifo_bank4 with a queue model and read-data scoreboard.
module tb_fifo_bank4;

    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    push;
    logic [3:0]    pop;
    logic [DW-1:0] data_in;
    logic [4*DW-1:0] data_out;
    logic [3:0]    empty, almost_empty, almost_full, full, err;
    logic          idle;

    fifo_bank4 #(.DATA_W(DW), .DEPTH(DEPTH), .AF_TH(AF), .AE_TH(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .empty        (empty),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .full         (full),
        .err          (err),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mq [4][$];
    logic [DW-1:0] sb [4][$];
    logic [DW-1:0] exp_do [4];
    logic [3:0]    exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [3:0] e_empty, e_ae, e_af, e_full;
        for (int c = 0; c < 4; c++) begin
            e_empty[c] = (mq[c].size() == 0);
            e_ae[c]    = (mq[c].size() <= AE);
            e_af[c]    = (mq[c].size() >= AF);
            e_full[c]  = (mq[c].size() == DEPTH);
            check($sformatf("data_out[%0d]", c), 64'(data_out[c*DW +: DW]), 64'(exp_do[c]));
        end
        check("empty", 64'(empty), 64'(e_empty));
        check("almost_empty", 64'(almost_empty), 64'(e_ae));
        check("almost_full", 64'(almost_full), 64'(e_af));
        check("full", 64'(full), 64'(e_full));
        check("err", 64'(err), 64'(exp_err));
        check("idle", 64'(idle), 64'(&e_empty));
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            sb[c].delete();
            exp_do[c] = '0;
        end
        exp_err = '0;
    endtask

    // One clock: drive strobes, update model with pre-edge occupancy, compare after edge.
    task automatic step(input logic [3:0] pu, input logic [3:0] po, input logic [DW-1:0] d);
        push    = pu;
        pop     = po;
        data_in = d;
        for (int c = 0; c < 4; c++) begin
            int n = mq[c].size();
            if (po[c]) begin
                if (n > 0) sb[c].push_back(mq[c].pop_front());
                else       exp_err[c] = 1'b1;
            end
            if (pu[c]) begin
                if (n < DEPTH || (po[c] && n > 0)) mq[c].push_back(d);
                else                               exp_err[c] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (sb[c].size() > 0) exp_do[c] = sb[c].pop_front();
        end
        check_all();
        push = '0;
        pop  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        push    = '0;
        pop     = '0;
        data_in = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Fill channel 2 past full, then drain
        for (int i = 1; i <= 9; i++) step(4'b0100, 4'b0000, DW'(i));
        for (int i = 0; i < 8; i++) step(4'b0000, 4'b0100, '0);

        // Pointer wrap with overlapping push/pop
        for (int i = 0; i < 10; i++) step(4'b0100, (i > 0) ? 4'b0100 : 4'b0000, DW'(12'h100 + i));
        step(4'b0000, 4'b0100, '0);

        // Underflow with same-cycle push on channel 0
        step(4'b0001, 4'b0001, 12'h0AB);
        step(4'b0000, 4'b0001, '0);

        // Channel 1 full boundary: push+pop together
        for (int i = 0; i < 8; i++) step(4'b0010, 4'b0000, DW'(12'h200 + i));
        step(4'b0010, 4'b0010, 12'h3FF);
        for (int i = 0; i < 8; i++) step(4'b0000, 4'b0010, '0);

        // Shared write word across channels 0 and 3, then async reset mid-cycle
        for (int i = 0; i < 5; i++) step(4'b1001, 4'b0000, DW'(12'h300 + i));
        step(4'b0000, 4'b0001, '0);
        #3;
        reset = 1'b1;
        #1;
        clear_model();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();

        // Normal operation resumes after reset
        step(4'b1000, 4'b0000, 12'h5A5);
        step(4'b0000, 4'b1000, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
